// File: rtl/rvfi_check_pkg.sv
// Shared types for the RVFI register-file consistency monitor.
// Error codes reported on err_kind, plus a register-index range helper.
package rvfi_check_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_ORDER = 3'd1,
    ERR_X0RD  = 3'd2,
    ERR_RS1   = 3'd3,
    ERR_RS2   = 3'd4,
    ERR_X0WR  = 3'd5,
    ERR_RANGE = 3'd6
  } err_kind_t;

  function automatic logic idx_ok(input logic [4:0] idx, input int nregs);
    return int'(idx) < nregs;
  endfunction

endpackage

// File: rtl/rvfi_regfile_check_if.sv
// RVFI retirement bus as seen by the register-file monitor.
// The core wrapper drives it (master); the monitor only observes it (slave).
interface rvfi_regfile_check_if #(
  parameter int NRET = 1,
  parameter int XLEN = 32
);
  logic [NRET-1:0]      rvfi_valid;
  logic [NRET*8-1:0]    rvfi_order;
  logic [NRET*5-1:0]    rvfi_rs1;
  logic [NRET*5-1:0]    rvfi_rs2;
  logic [NRET*5-1:0]    rvfi_rd;
  logic [NRET*XLEN-1:0] rvfi_pre_rs1;
  logic [NRET*XLEN-1:0] rvfi_pre_rs2;
  logic [NRET*XLEN-1:0] rvfi_post_rd;
  logic [NRET-1:0]      rvfi_trap;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_rs1, rvfi_rs2, rvfi_rd,
           rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_rd, rvfi_trap
  );

  modport slave (
    input rvfi_valid, rvfi_order, rvfi_rs1, rvfi_rs2, rvfi_rd,
          rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_rd, rvfi_trap
  );
endinterface

// File: rtl/rvfi_regfile_check_chan.sv
// One retirement channel: checks against the incoming (bypassed) shadow state
// and produces the shadow/order state seen by the next channel.
module rvfi_regfile_check_chan
  import rvfi_check_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                         valid,
  input  logic [7:0]                   order,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic [4:0]                   rd,
  input  logic [XLEN-1:0]              pre_rs1,
  input  logic [XLEN-1:0]              pre_rs2,
  input  logic [XLEN-1:0]              post_rd,
  input  logic                         trap,
  input  logic [NREGS-1:0][XLEN-1:0]   shadow_in,
  input  logic [NREGS-1:0]             written_in,
  input  logic                         order_seen_in,
  input  logic [7:0]                   last_order_in,
  output logic [NREGS-1:0][XLEN-1:0]   shadow_out,
  output logic [NREGS-1:0]             written_out,
  output logic                         order_seen_out,
  output logic [7:0]                   last_order_out,
  output err_kind_t                    kind,
  output logic [4:0]                   kind_reg,
  output logic [2:0]                   hit_cnt
);

  logic rs1_ok, rs2_ok, rd_ok;
  logic e_order, e_x0rd, e_rs1, e_rs2, e_x0wr, e_range;

  always_comb begin
    rs1_ok  = idx_ok(rs1, NREGS);
    rs2_ok  = idx_ok(rs2, NREGS);
    rd_ok   = idx_ok(rd, NREGS);
    e_order = valid && order_seen_in && (order != last_order_in + 8'd1);
    e_x0rd  = valid && ((rs1 == 5'd0 && pre_rs1 != '0) || (rs2 == 5'd0 && pre_rs2 != '0));
    e_rs1   = valid && rs1 != 5'd0 && rs1_ok && written_in[rs1] && shadow_in[rs1] != pre_rs1;
    e_rs2   = valid && rs2 != 5'd0 && rs2_ok && written_in[rs2] && shadow_in[rs2] != pre_rs2;
    e_x0wr  = valid && !trap && rd == 5'd0 && post_rd != '0;
    e_range = valid && ((!trap && !rd_ok) || !rs1_ok || !rs2_ok);
    hit_cnt = {2'b0, e_order} + {2'b0, e_x0rd} + {2'b0, e_rs1} +
              {2'b0, e_rs2} + {2'b0, e_x0wr} + {2'b0, e_range};

    kind     = ERR_NONE;
    kind_reg = 5'd0;
    if (e_order) begin
      kind     = ERR_ORDER;
      kind_reg = rd;
    end else if (e_x0rd) begin
      kind     = ERR_X0RD;
      kind_reg = 5'd0;
    end else if (e_rs1) begin
      kind     = ERR_RS1;
      kind_reg = rs1;
    end else if (e_rs2) begin
      kind     = ERR_RS2;
      kind_reg = rs2;
    end else if (e_x0wr) begin
      kind     = ERR_X0WR;
      kind_reg = 5'd0;
    end else if (e_range) begin
      kind     = ERR_RANGE;
      kind_reg = (!trap && !rd_ok) ? rd : (!rs1_ok ? rs1 : rs2);
    end

    // Bypass: later channels of the same cycle see this channel's write.
    shadow_out     = shadow_in;
    written_out    = written_in;
    order_seen_out = order_seen_in || valid;
    last_order_out = valid ? order : last_order_in;
    if (valid && !trap && rd != 5'd0 && rd_ok) begin
      shadow_out[rd]  = post_rd;
      written_out[rd] = 1'b1;
    end
  end

endmodule

// File: rtl/rvfi_regfile_check.sv
// RVFI register-file consistency monitor: shadows every architectural register,
// chains per-channel checks and records the first error plus running counters.
module rvfi_regfile_check
  import rvfi_check_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter int NREGS     = 32,
  parameter int ZERO_INIT = 0,
  parameter int ASSERT_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  rvfi_regfile_check_if.slave  rvfi,
  output logic                 err,
  output logic [2:0]           err_kind,
  output logic [7:0]           err_order,
  output logic [4:0]           err_reg,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          ret_count
);

  logic [NREGS-1:0][XLEN-1:0] shadow_q;
  logic [NREGS-1:0]           written_q;
  logic                       order_seen_q;
  logic [7:0]                 last_order_q;

  logic [NRET:0][NREGS-1:0][XLEN-1:0] sh_c;
  logic [NRET:0][NREGS-1:0]           wr_c;
  logic [NRET:0]                      seen_c;
  logic [NRET:0][7:0]                 last_c;
  err_kind_t                          kind_c [NRET];
  logic [4:0]                         reg_c  [NRET];
  logic [2:0]                         hits_c [NRET];

  assign sh_c[0]   = shadow_q;
  assign wr_c[0]   = written_q;
  assign seen_c[0] = order_seen_q;
  assign last_c[0] = last_order_q;

  for (genvar g = 0; g < NRET; g++) begin : g_chan
    rvfi_regfile_check_chan #(.XLEN(XLEN), .NREGS(NREGS)) u_chan (
      .valid          (rvfi.rvfi_valid[g]),
      .order          (rvfi.rvfi_order[8*g +: 8]),
      .rs1            (rvfi.rvfi_rs1[5*g +: 5]),
      .rs2            (rvfi.rvfi_rs2[5*g +: 5]),
      .rd             (rvfi.rvfi_rd[5*g +: 5]),
      .pre_rs1        (rvfi.rvfi_pre_rs1[XLEN*g +: XLEN]),
      .pre_rs2        (rvfi.rvfi_pre_rs2[XLEN*g +: XLEN]),
      .post_rd        (rvfi.rvfi_post_rd[XLEN*g +: XLEN]),
      .trap           (rvfi.rvfi_trap[g]),
      .shadow_in      (sh_c[g]),
      .written_in     (wr_c[g]),
      .order_seen_in  (seen_c[g]),
      .last_order_in  (last_c[g]),
      .shadow_out     (sh_c[g+1]),
      .written_out    (wr_c[g+1]),
      .order_seen_out (seen_c[g+1]),
      .last_order_out (last_c[g+1]),
      .kind           (kind_c[g]),
      .kind_reg       (reg_c[g]),
      .hit_cnt        (hits_c[g])
    );
  end

  logic                 sel_found;
  err_kind_t            sel_kind;
  logic [7:0]           sel_order;
  logic [4:0]           sel_reg;
  logic [ERR_CNT_W-1:0] hit_sum;
  logic [ERR_CNT_W:0]   cnt_sum;
  logic [31:0]          valid_sum;

  // Lowest channel with any hit supplies the first-error record.
  always_comb begin
    sel_found = 1'b0;
    sel_kind  = ERR_NONE;
    sel_order = 8'd0;
    sel_reg   = 5'd0;
    hit_sum   = '0;
    valid_sum = '0;
    for (int c = 0; c < NRET; c++) begin
      hit_sum   = hit_sum + ERR_CNT_W'(hits_c[c]);
      valid_sum = valid_sum + 32'(rvfi.rvfi_valid[c]);
      if (!sel_found && kind_c[c] != ERR_NONE) begin
        sel_found = 1'b1;
        sel_kind  = kind_c[c];
        sel_order = rvfi.rvfi_order[8*c +: 8];
        sel_reg   = reg_c[c];
      end
    end
    cnt_sum = {1'b0, err_count} + {1'b0, hit_sum};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q     <= '0;
      written_q    <= (ZERO_INIT != 0) ? '1 : '0;
      order_seen_q <= 1'b0;
      last_order_q <= 8'd0;
      err          <= 1'b0;
      err_kind     <= 3'd0;
      err_order    <= 8'd0;
      err_reg      <= 5'd0;
      err_count    <= '0;
      ret_count    <= 32'd0;
    end else begin
      shadow_q     <= sh_c[NRET];
      written_q    <= wr_c[NRET];
      order_seen_q <= seen_c[NRET];
      last_order_q <= last_c[NRET];
      ret_count    <= ret_count + valid_sum;
      err_count    <= cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
      if (!err && sel_found) begin
        err       <= 1'b1;
        err_kind  <= sel_kind;
        err_order <= sel_order;
        err_reg   <= sel_reg;
      end
    end
  end

  always_comb begin
    if (ASSERT_EN != 0 && !reset) assert (!sel_found);
  end

endmodule

// File: tb/tb_rvfi_regfile_check.sv
// Scoreboard bench: dut_a is single-channel without zero-init, dut_b is
// two-channel with zero-init; expected snapshots are queued per drive.
module tb_rvfi_regfile_check;

  typedef struct packed {
    logic        valid;
    logic [7:0]  order;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pre1;
    logic [31:0] pre2;
    logic [31:0] post;
    logic        trap;
  } ch_t;

  typedef struct packed {
    logic        err;
    logic [2:0]  kind;
    logic [7:0]  order;
    logic [4:0]  rg;
    logic [15:0] cnt;
    logic [31:0] ret;
  } exp_t;

  localparam logic [2:0] K_NONE = 3'd0, K_ORDER = 3'd1, K_X0RD = 3'd2,
                         K_RS1 = 3'd3, K_RS2 = 3'd4, K_X0WR = 3'd5;
  localparam ch_t  NOP  = '0;
  localparam exp_t ZERO = '0;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  rvfi_regfile_check_if #(.NRET(1), .XLEN(32)) ia ();
  rvfi_regfile_check_if #(.NRET(2), .XLEN(32)) ib ();

  logic        a_err, b_err;
  logic [2:0]  a_kind, b_kind;
  logic [7:0]  a_order, b_order;
  logic [4:0]  a_reg, b_reg;
  logic [15:0] a_cnt, b_cnt;
  logic [31:0] a_ret, b_ret;

  rvfi_regfile_check #(.XLEN(32), .NRET(1), .NREGS(32), .ZERO_INIT(0), .ASSERT_EN(0)) dut_a (
    .clk(clk), .reset(rst_a), .rvfi(ia),
    .err(a_err), .err_kind(a_kind), .err_order(a_order), .err_reg(a_reg),
    .err_count(a_cnt), .ret_count(a_ret)
  );

  rvfi_regfile_check #(.XLEN(32), .NRET(2), .NREGS(32), .ZERO_INIT(1), .ASSERT_EN(0)) dut_b (
    .clk(clk), .reset(rst_b), .rvfi(ib),
    .err(b_err), .err_kind(b_kind), .err_order(b_order), .err_reg(b_reg),
    .err_count(b_cnt), .ret_count(b_ret)
  );

  function automatic ch_t ch(input logic [7:0] order, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] pre1, input logic [31:0] pre2,
                             input logic [31:0] post, input logic trap);
    ch_t c;
    c = '{valid: 1'b1, order: order, rs1: rs1, rs2: rs2, rd: rd,
          pre1: pre1, pre2: pre2, post: post, trap: trap};
    return c;
  endfunction

  function automatic exp_t ex(input logic err, input logic [2:0] kind, input logic [7:0] order,
                              input logic [4:0] rg, input logic [15:0] cnt, input logic [31:0] ret);
    exp_t e;
    e = '{err: err, kind: kind, order: order, rg: rg, cnt: cnt, ret: ret};
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("err=%0d kind=%0d order=%0d reg=%0d cnt=%0d ret=%0d",
                     e.err, e.kind, e.order, e.rg, e.cnt, e.ret);
  endfunction

  function automatic exp_t snap_a();
    return ex(a_err, a_kind, a_order, a_reg, a_cnt, a_ret);
  endfunction

  function automatic exp_t snap_b();
    return ex(b_err, b_kind, b_order, b_reg, b_cnt, b_ret);
  endfunction

  task automatic apply_a(input ch_t c);
    ia.rvfi_valid   = c.valid;
    ia.rvfi_order   = c.order;
    ia.rvfi_rs1     = c.rs1;
    ia.rvfi_rs2     = c.rs2;
    ia.rvfi_rd      = c.rd;
    ia.rvfi_pre_rs1 = c.pre1;
    ia.rvfi_pre_rs2 = c.pre2;
    ia.rvfi_post_rd = c.post;
    ia.rvfi_trap    = c.trap;
  endtask

  task automatic apply_b(input ch_t c0, input ch_t c1);
    ib.rvfi_valid   = {c1.valid, c0.valid};
    ib.rvfi_order   = {c1.order, c0.order};
    ib.rvfi_rs1     = {c1.rs1, c0.rs1};
    ib.rvfi_rs2     = {c1.rs2, c0.rs2};
    ib.rvfi_rd      = {c1.rd, c0.rd};
    ib.rvfi_pre_rs1 = {c1.pre1, c0.pre1};
    ib.rvfi_pre_rs2 = {c1.pre2, c0.pre2};
    ib.rvfi_post_rd = {c1.post, c0.post};
    ib.rvfi_trap    = {c1.trap, c0.trap};
  endtask

  task automatic drive_a(input ch_t c, input exp_t e);
    @(negedge clk);
    apply_a(c);
    q_a.push_back(e);
    @(posedge clk);
    #1;
    apply_a(NOP);
  endtask

  task automatic drive_b(input ch_t c0, input ch_t c1, input exp_t e);
    @(negedge clk);
    apply_b(c0, c1);
    q_b.push_back(e);
    @(posedge clk);
    #1;
    apply_b(NOP, NOP);
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    reset_a();
    reset_b();
    got = snap_a();
    tests_run++;
    if (got !== ZERO) begin
      tests_failed++;
      $display("FAIL reset_a: got %s, want %s", fmt(got), fmt(ZERO));
    end
    got = snap_b();
    tests_run++;
    if (got !== ZERO) begin
      tests_failed++;
      $display("FAIL reset_b: got %s, want %s", fmt(got), fmt(ZERO));
    end
  endtask

  task automatic test_write_read();
    ch_t s[2];
    exp_t w[2];
    exp_t got, e;
    reset_a();
    s[0] = ch(8'd0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h1234, 1'b0);
    w[0] = ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd1);
    s[1] = ch(8'd1, 5'd5, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 1'b0);
    w[1] = ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd2);
    for (int i = 0; i < 2; i++) begin
      drive_a(s[i], w[i]);
      got = snap_a();
      e = q_a.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL write_read[%0d]: got %s, want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_rs2_mismatch();
    exp_t got, e;
    reset_a();
    drive_a(ch(8'd0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h1234, 1'b0),
            ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd1));
    void'(q_a.pop_front());
    drive_a(ch(8'd1, 5'd0, 5'd5, 5'd0, 32'h0, 32'h1235, 32'h0, 1'b0),
            ex(1'b1, K_RS2, 8'd1, 5'd5, 16'd1, 32'd2));
    got = snap_a();
    e = q_a.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL rs2_mismatch: got %s, want %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_order();
    logic [7:0] ords[2][3];
    exp_t w[2][3];
    exp_t got, e;
    ords[0] = '{8'd0, 8'd1, 8'd3};
    ords[1] = '{8'd254, 8'd255, 8'd0};
    w[0] = '{ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd1),
             ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd2),
             ex(1'b1, K_ORDER, 8'd3, 5'd0, 16'd1, 32'd3)};
    w[1] = '{ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd1),
             ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd2),
             ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd3)};
    for (int r = 0; r < 2; r++) begin
      reset_a();
      for (int i = 0; i < 3; i++) begin
        drive_a(ch(ords[r][i], 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0), w[r][i]);
        got = snap_a();
        e = q_a.pop_front();
        tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("FAIL order[%0d][%0d]: got %s, want %s", r, i, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t got, e;
    reset_a();
    drive_a(ch(8'd0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h55, 1'b0),
            ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd1));
    void'(q_a.pop_front());
    drive_a(ch(8'd1, 5'd9, 5'd0, 5'd0, 32'h56, 32'h0, 32'h0, 1'b0),
            ex(1'b1, K_RS1, 8'd1, 5'd9, 16'd1, 32'd2));
    got = snap_a();
    e = q_a.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL mid_rs1_err: got %s, want %s", fmt(got), fmt(e));
    end
    // One reset cycle carrying an X0WR that must not be counted.
    @(negedge clk);
    rst_a = 1'b1;
    apply_a(ch(8'd9, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1, 1'b0));
    q_a.push_back(ZERO);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    apply_a(NOP);
    got = snap_a();
    e = q_a.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: got %s, want %s", fmt(got), fmt(e));
    end
    drive_a(ch(8'd5, 5'd9, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0),
            ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd1));
    got = snap_a();
    e = q_a.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL mid_unwritten_read: got %s, want %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_bypass();
    exp_t got, e;
    reset_b();
    drive_b(ch(8'd0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA, 1'b0),
            ch(8'd1, 5'd7, 5'd0, 5'd0, 32'hA, 32'h0, 32'h0, 1'b0),
            ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd2));
    got = snap_b();
    e = q_b.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL bypass_ok: got %s, want %s", fmt(got), fmt(e));
    end
    drive_b(ch(8'd2, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA, 1'b0),
            ch(8'd3, 5'd7, 5'd0, 5'd0, 32'hB, 32'h0, 32'h0, 1'b0),
            ex(1'b1, K_RS1, 8'd3, 5'd7, 16'd1, 32'd4));
    got = snap_b();
    e = q_b.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL bypass_rs1_err: got %s, want %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_same_rd();
    exp_t got, e;
    reset_b();
    drive_b(ch(8'd0, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h1, 1'b0),
            ch(8'd1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h2, 1'b0),
            ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd2));
    got = snap_b();
    e = q_b.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL same_rd_write: got %s, want %s", fmt(got), fmt(e));
    end
    drive_b(ch(8'd2, 5'd8, 5'd0, 5'd0, 32'h2, 32'h0, 32'h0, 1'b0),
            ch(8'd3, 5'd0, 5'd8, 5'd0, 32'h0, 32'h1, 32'h0, 1'b0),
            ex(1'b1, K_RS2, 8'd3, 5'd8, 16'd1, 32'd4));
    got = snap_b();
    e = q_b.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL same_rd_high_wins: got %s, want %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_trap_x0();
    ch_t s[4];
    exp_t w[4];
    exp_t got, e;
    reset_b();
    s[0] = ch(8'd0, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h99, 1'b1);
    w[0] = ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd1);
    s[1] = ch(8'd1, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    w[1] = ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd2);
    s[2] = ch(8'd2, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1, 1'b0);
    w[2] = ex(1'b1, K_X0WR, 8'd2, 5'd0, 16'd1, 32'd3);
    s[3] = ch(8'd3, 5'd0, 5'd0, 5'd0, 32'h7, 32'h0, 32'h0, 1'b0);
    w[3] = ex(1'b1, K_X0WR, 8'd2, 5'd0, 16'd2, 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive_b(s[i], NOP, w[i]);
      got = snap_b();
      e = q_b.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL trap_x0[%0d]: got %s, want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_first_select();
    exp_t got, e;
    reset_b();
    drive_b(ch(8'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0), NOP,
            ex(1'b0, K_NONE, 8'd0, 5'd0, 16'd0, 32'd1));
    got = snap_b();
    e = q_b.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL first_sel_pre: got %s, want %s", fmt(got), fmt(e));
    end
    // ch0: ORDER + X0RD, ch1: X0WR -> three hits, ch0's ORDER recorded.
    drive_b(ch(8'd5, 5'd0, 5'd0, 5'd0, 32'h1, 32'h0, 32'h0, 1'b0),
            ch(8'd6, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h5, 1'b0),
            ex(1'b1, K_ORDER, 8'd5, 5'd0, 16'd3, 32'd3));
    got = snap_b();
    e = q_b.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL first_sel_multi: got %s, want %s", fmt(got), fmt(e));
    end
  endtask

  initial begin
    apply_a(NOP);
    apply_b(NOP, NOP);
    test_reset();
    test_write_read();
    test_rs2_mismatch();
    test_order();
    test_reset_mid_run();
    test_bypass();
    test_same_rd();
    test_trap_x0();
    test_first_select();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want bench completion");
    $fatal(1, "timeout");
  end

endmodule
